// File: rtl/psk_mapper_pkg.sv
// Shared definitions for the PSK symbol mapper: modulation enum, amplitude defaults,
// gray-label to constellation-position tables and position to axis/sign tables.
package psk_mapper_pkg;

  typedef enum logic {
    MOD_QPSK = 1'b0,
    MOD_8PSK = 1'b1
  } mod_t;

  localparam int IQ_W_DEF     = 10;
  localparam int AMP_QPSK_DEF = 180;
  localparam int AMP_HI_DEF   = 236;
  localparam int AMP_LO_DEF   = 98;

  // i_hi selects the large magnitude for I; 8-PSK Q always takes the other magnitude
  typedef struct packed {
    logic i_neg;
    logic q_neg;
    logic i_hi;
  } axes_t;

  function automatic logic [2:0] qpsk_pos(input logic [1:0] label);
    logic [2:0] pos;
    pos = 3'd0;
    case (label)
      2'b00: pos = 3'd0;
      2'b01: pos = 3'd1;
      2'b11: pos = 3'd2;
      2'b10: pos = 3'd3;
      default: pos = 3'd0;
    endcase
    return pos;
  endfunction

  function automatic logic [2:0] psk8_pos(input logic [2:0] label);
    logic [2:0] pos;
    pos = 3'd0;
    case (label)
      3'b000: pos = 3'd0;
      3'b001: pos = 3'd1;
      3'b011: pos = 3'd2;
      3'b010: pos = 3'd3;
      3'b110: pos = 3'd4;
      3'b111: pos = 3'd5;
      3'b101: pos = 3'd6;
      3'b100: pos = 3'd7;
      default: pos = 3'd0;
    endcase
    return pos;
  endfunction

  function automatic axes_t qpsk_axes(input logic [1:0] pos);
    axes_t a;
    a = '{i_neg: 1'b0, q_neg: 1'b0, i_hi: 1'b1};
    case (pos)
      2'd0: begin a.i_neg = 1'b0; a.q_neg = 1'b0; end
      2'd1: begin a.i_neg = 1'b1; a.q_neg = 1'b0; end
      2'd2: begin a.i_neg = 1'b1; a.q_neg = 1'b1; end
      2'd3: begin a.i_neg = 1'b0; a.q_neg = 1'b1; end
      default: a = '{i_neg: 1'b0, q_neg: 1'b0, i_hi: 1'b1};
    endcase
    return a;
  endfunction

  function automatic axes_t psk8_axes(input logic [2:0] pos);
    axes_t a;
    a = '{i_neg: 1'b0, q_neg: 1'b0, i_hi: 1'b1};
    case (pos)
      3'd0: a = '{i_neg: 1'b0, q_neg: 1'b0, i_hi: 1'b1};
      3'd1: a = '{i_neg: 1'b0, q_neg: 1'b0, i_hi: 1'b0};
      3'd2: a = '{i_neg: 1'b1, q_neg: 1'b0, i_hi: 1'b0};
      3'd3: a = '{i_neg: 1'b1, q_neg: 1'b0, i_hi: 1'b1};
      3'd4: a = '{i_neg: 1'b1, q_neg: 1'b1, i_hi: 1'b1};
      3'd5: a = '{i_neg: 1'b1, q_neg: 1'b1, i_hi: 1'b0};
      3'd6: a = '{i_neg: 1'b0, q_neg: 1'b1, i_hi: 1'b0};
      3'd7: a = '{i_neg: 1'b0, q_neg: 1'b1, i_hi: 1'b1};
      default: a = '{i_neg: 1'b0, q_neg: 1'b0, i_hi: 1'b1};
    endcase
    return a;
  endfunction

endpackage

// File: rtl/psk_mapper_if.sv
// Word input and I/Q output bundle of the PSK mapper; master drives words, slave is the mapper.
interface psk_mapper_if #(
  parameter int IQ_W = 10
);
  logic                   i_mod_8psk;
  logic                   i_diff_en;
  logic                   i_vld;
  logic [1:0]             i_word;
  logic                   o_vld;
  logic signed [IQ_W-1:0] o_data_I;
  logic signed [IQ_W-1:0] o_data_Q;

  modport master (
    output i_mod_8psk, i_diff_en, i_vld, i_word,
    input  o_vld, o_data_I, o_data_Q
  );

  modport slave (
    input  i_mod_8psk, i_diff_en, i_vld, i_word,
    output o_vld, o_data_I, o_data_Q
  );
endinterface

// File: rtl/psk_mapper_gearbox.sv
// 2-to-3 bit gearbox for 8-PSK: collects 2-bit words and releases 3-bit symbols,
// oldest bit in the symbol MSB. Symbol strobe is combinational from the incoming word.
module psk_mapper_gearbox (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       vld,
  input  logic [1:0] bits,
  input  logic       flush,
  output logic       sym_vld,
  output logic [2:0] sym
);

  // Between words at most two bits remain, so only those are kept; the 4-bit view is rebuilt per word
  logic [1:0] pend_q, pend_next, pend_base;
  logic [2:0] cnt_q, cnt_next, cnt_base, sum;
  logic [3:0] joined;

  always_comb begin
    pend_base = flush ? 2'b00 : pend_q;
    cnt_base  = flush ? 3'd0 : cnt_q;
    joined    = {pend_base, bits};
    sum       = cnt_base + 3'd2;
    pend_next = pend_base;
    cnt_next  = cnt_base;
    sym_vld   = 1'b0;
    sym       = 3'b000;
    if (vld) begin
      pend_next = joined[1:0];
      if (sum >= 3'd3) begin
        sym_vld  = 1'b1;
        sym      = (sum == 3'd4) ? joined[3:1] : joined[2:0];
        cnt_next = sum - 3'd3;
      end else begin
        cnt_next = sum;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_q <= 2'b00;
      cnt_q  <= 3'd0;
    end else begin
      pend_q <= pend_next;
      cnt_q  <= cnt_next;
    end
  end

endmodule

// File: rtl/psk_mapper.sv
// Transmit symbol mapper: 2-bit coded words to signed I/Q samples in QPSK or 8-PSK,
// with optional differential phase encoding and a one-cycle registered output.
module psk_mapper
  import psk_mapper_pkg::*;
#(
  parameter int IQ_W     = IQ_W_DEF,
  parameter int AMP_QPSK = AMP_QPSK_DEF,
  parameter int AMP_HI   = AMP_HI_DEF,
  parameter int AMP_LO   = AMP_LO_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  psk_mapper_if.slave  bus
);

  localparam logic signed [IQ_W-1:0] MAG_Q  = IQ_W'(AMP_QPSK);
  localparam logic signed [IQ_W-1:0] MAG_HI = IQ_W'(AMP_HI);
  localparam logic signed [IQ_W-1:0] MAG_LO = IQ_W'(AMP_LO);

  mod_t                   mode_q, mode_new;
  logic                   mode_change, is_8psk, emit;
  logic [2:0]             acc_q, acc_base, acc_next;
  logic [2:0]             pos_raw, pos, pos_mask;
  logic                   sym_vld;
  logic [2:0]             sym;
  axes_t                  axes;
  logic signed [IQ_W-1:0] mag_i, mag_q, i_val, q_val;
  logic                   vld_q;
  logic signed [IQ_W-1:0] i_q, q_q;

  assign mode_new    = mod_t'(bus.i_mod_8psk);
  assign mode_change = (mode_new != mode_q);
  assign is_8psk     = (mode_new == MOD_8PSK);

  // A mode switch empties the buffer in the same cycle, so a word arriving now starts the new mode
  psk_mapper_gearbox u_gearbox (
    .clk     (clk),
    .reset_n (reset_n),
    .vld     (bus.i_vld && is_8psk),
    .bits    (bus.i_word),
    .flush   (mode_change),
    .sym_vld (sym_vld),
    .sym     (sym)
  );

  // Phase rotation: the accumulator restarts from zero on mode switch or whenever diff is off
  always_comb begin
    acc_base = (mode_change || !bus.i_diff_en) ? 3'd0 : acc_q;
    emit     = is_8psk ? sym_vld : bus.i_vld;
    pos_raw  = is_8psk ? psk8_pos(sym) : qpsk_pos(bus.i_word);
    pos_mask = is_8psk ? 3'd7 : 3'd3;
    pos      = bus.i_diff_en ? ((acc_base + pos_raw) & pos_mask) : pos_raw;
    acc_next = acc_base;
    if (emit && bus.i_diff_en) begin
      acc_next = pos;
    end
  end

  always_comb begin
    axes  = is_8psk ? psk8_axes(pos) : qpsk_axes(pos[1:0]);
    mag_i = MAG_Q;
    mag_q = MAG_Q;
    if (is_8psk) begin
      mag_i = axes.i_hi ? MAG_HI : MAG_LO;
      mag_q = axes.i_hi ? MAG_LO : MAG_HI;
    end
    i_val = axes.i_neg ? -mag_i : mag_i;
    q_val = axes.q_neg ? -mag_q : mag_q;
  end

  // I/Q registers only load on a symbol, so they hold between strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= MOD_QPSK;
      acc_q  <= 3'd0;
      vld_q  <= 1'b0;
      i_q    <= '0;
      q_q    <= '0;
    end else begin
      mode_q <= mode_new;
      acc_q  <= acc_next;
      vld_q  <= emit;
      if (emit) begin
        i_q <= i_val;
        q_q <= q_val;
      end
    end
  end

  assign bus.o_vld    = vld_q;
  assign bus.o_data_I = i_q;
  assign bus.o_data_Q = q_q;

endmodule

// File: tb/tb_psk_mapper.sv
// Scoreboard bench for psk_mapper: a bit-queue/phase reference model predicts each symbol,
// a negedge monitor compares every strobe and checks I/Q hold between strobes.
module tb_psk_mapper;

  typedef struct {
    int i;
    int q;
    int cyc;
  } exp_t;

  localparam int A = 180;
  localparam int H = 236;
  localparam int L = 98;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  psk_mapper_if #(.IQ_W(10)) bus();

  psk_mapper #(.IQ_W(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Gray label -> position, and position -> constellation point
  int qpsk_k[4]  = '{0, 1, 3, 2};
  int psk8_k[8]  = '{0, 1, 3, 2, 7, 6, 4, 5};
  int qpsk_i[4]  = '{A, -A, -A, A};
  int qpsk_q[4]  = '{A, A, -A, -A};
  int psk8_i[8]  = '{H, L, -L, -H, -H, -L, L, H};
  int psk8_q[8]  = '{L, H, H, L, -L, -H, -H, -L};

  exp_t exp_q[$];
  int   bitq[$];
  int   m_mode = 0;
  int   m_acc = 0;
  int   last_i = 0;
  int   last_q = 0;
  int   cyc = 0;
  int   vld_seen = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("[TB] FAIL %s got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic modelEmit(input int k, input int m, input bit diff);
    int outk;
    exp_t e;
    outk  = diff ? (m_acc + k) % m : k;
    m_acc = diff ? outk : 0;
    e.i   = (m == 8) ? psk8_i[outk] : qpsk_i[outk];
    e.q   = (m == 8) ? psk8_q[outk] : qpsk_q[outk];
    e.cyc = cyc;
    exp_q.push_back(e);
  endtask

  // One clock cycle of input; the model sees the same cycle the DUT will sample
  task automatic applyStimulus(input bit vld, input bit [1:0] word, input bit mode8, input bit diff);
    int label;
    bus.i_vld      = vld;
    bus.i_word     = word;
    bus.i_mod_8psk = mode8;
    bus.i_diff_en  = diff;
    if (int'(mode8) != m_mode) begin
      bitq.delete();
      m_acc  = 0;
      m_mode = int'(mode8);
    end
    if (!diff) m_acc = 0;
    if (vld) begin
      if (!mode8) begin
        modelEmit(qpsk_k[word], 4, diff);
      end else begin
        bitq.push_back(int'(word[1]));
        bitq.push_back(int'(word[0]));
        if (bitq.size() >= 3) begin
          label = bitq.pop_front() * 4;
          label += bitq.pop_front() * 2;
          label += bitq.pop_front();
          modelEmit(psk8_k[label], 8, diff);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    bus.i_vld = 1'b0;
    reset_n   = 1'b0;
    bitq.delete();
    exp_q.delete();
    m_acc  = 0;
    m_mode = 0;
    last_i = 0;
    last_q = 0;
    @(posedge clk);
    #1;
    checkOutput("reset_vld", int'(bus.o_vld), 0);
    checkOutput("reset_I", int'(bus.o_data_I), 0);
    checkOutput("reset_Q", int'(bus.o_data_Q), 0);
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (bus.o_vld) begin
        vld_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_vld got=1 want=0 (cycle %0d)", cyc);
        end else begin
          e = exp_q.pop_front();
          checkOutput("data_I", int'(bus.o_data_I), e.i);
          checkOutput("data_Q", int'(bus.o_data_Q), e.q);
          checkOutput("latency_cycle", cyc, e.cyc + 1);
          last_i = e.i;
          last_q = e.q;
        end
      end else begin
        checkOutput("hold_I", int'(bus.o_data_I), last_i);
        checkOutput("hold_Q", int'(bus.o_data_Q), last_q);
      end
    end
  end

  initial begin
    int base;
    bit mode8;
    bit diff;
    bus.i_vld      = 1'b0;
    bus.i_word     = 2'b00;
    bus.i_mod_8psk = 1'b0;
    bus.i_diff_en  = 1'b0;
    @(posedge clk);
    #1;
    doReset();

    // QPSK, diff off, four words back to back
    applyStimulus(1, 2'b00, 0, 0);
    applyStimulus(1, 2'b01, 0, 0);
    applyStimulus(1, 2'b10, 0, 0);
    applyStimulus(1, 2'b11, 0, 0);
    repeat (2) applyStimulus(0, 2'b00, 0, 0);

    // 8-PSK, diff off: 000 then 111
    applyStimulus(1, 2'b00, 1, 0);
    applyStimulus(1, 2'b01, 1, 0);
    applyStimulus(1, 2'b11, 1, 0);
    repeat (2) applyStimulus(0, 2'b00, 1, 0);

    // 8-PSK, diff on: symbol 001 four times walks k = 1..4
    applyStimulus(1, 2'b00, 1, 1);
    applyStimulus(1, 2'b10, 1, 1);
    applyStimulus(1, 2'b01, 1, 1);
    applyStimulus(1, 2'b00, 1, 1);
    applyStimulus(1, 2'b10, 1, 1);
    applyStimulus(1, 2'b01, 1, 1);
    repeat (2) applyStimulus(0, 2'b00, 1, 0);

    // 8-PSK sparse words: two strobes per three words
    base = vld_seen;
    for (int w = 0; w < 6; w++) begin
      applyStimulus(1, 2'($urandom_range(0, 3)), 1, 0);
      repeat (63) applyStimulus(0, 2'b00, 1, 0);
    end
    checkOutput("sparse_vld_count", vld_seen - base, 4);

    // Single 8-PSK word, then switch to QPSK with word 11 in the same cycle
    applyStimulus(1, 2'b01, 1, 0);
    applyStimulus(1, 2'b11, 0, 0);
    repeat (2) applyStimulus(0, 2'b00, 0, 0);

    // Reset mid-symbol, then three words as from cold
    applyStimulus(1, 2'b10, 1, 0);
    bus.i_vld = 1'b0;
    doReset();
    applyStimulus(1, 2'b11, 1, 0);
    applyStimulus(1, 2'b01, 1, 0);
    applyStimulus(1, 2'b10, 1, 0);
    repeat (2) applyStimulus(0, 2'b00, 1, 0);

    // Random words, gaps, mode and diff toggles
    mode8 = 1'b0;
    diff  = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 24) == 0) mode8 = ~mode8;
      if ($urandom_range(0, 19) == 0) diff = ~diff;
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), mode8, diff);
    end
    repeat (3) applyStimulus(0, 2'b00, mode8, diff);

    checkOutput("pending_expected", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
